// File: rtl/pio_led_pkg.sv
// Shared register map for the PIO LED blink peripheral.
package pio_led_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA       = 3'd0,
        ADDR_SET        = 3'd1,
        ADDR_CLR        = 3'd2,
        ADDR_TOGGLE     = 3'd3,
        ADDR_BLINK_MASK = 3'd4,
        ADDR_PERIOD     = 3'd5,
        ADDR_STATUS     = 3'd6,
        ADDR_RSVD       = 3'd7
    } reg_addr_e;

    localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/pio_led_blink_timer.sv
// Free-running blink timer: phase toggles each time the counter wraps past period.
module blink_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] period,
    input  logic             restart,
    output logic             phase
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (cnt_q == period) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
        // A new period always starts from a clean phase, even on a wrap edge.
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/pio_led_blink.sv
// Avalon-MM PIO with set/clear/toggle aliases and per-bit hardware blinking.
module pio_led_blink
    import pio_led_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DIV_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [WIDTH-1:0] wd;
    logic             wr_en;
    logic             restart;
    logic             phase;
    logic             unused_wd;
    reg_addr_e        addr;

    assign addr      = reg_addr_e'(address);
    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        restart  = 1'b0;
        if (wr_en) begin
            case (addr)
                ADDR_DATA:       data_d = wd;
                ADDR_SET:        data_d = data_q | wd;
                ADDR_CLR:        data_d = data_q & ~wd;
                ADDR_TOGGLE:     data_d = data_q ^ wd;
                ADDR_BLINK_MASK: mask_d = wd;
                ADDR_PERIOD: begin
                    period_d = writedata[DIV_W-1:0];
                    restart  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Blinking bits are forced dark during the high half of the phase.
    assign out_d = data_q & ~(mask_q & {WIDTH{phase}});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            mask_q   <= '0;
            period_q <= '1;
            out_q    <= RESET_VALUE;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            out_q    <= out_d;
        end
    end

    blink_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_q),
        .restart (restart),
        .phase   (phase)
    );

    always_comb begin
        readdata = '0;
        case (addr)
            ADDR_DATA:       readdata[WIDTH-1:0] = data_q;
            ADDR_BLINK_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_PERIOD:     readdata[DIV_W-1:0] = period_q;
            ADDR_STATUS:     readdata[STATUS_PHASE_BIT] = phase;
            default: ;
        endcase
    end

    assign out_port = out_q;

endmodule

// File: doc/pio_led_blink.md
PIO_LED_BLINK -- requirements
Module: pio_led_blink

Interface
REQ-001 Parameter WIDTH, default 8, number of output bits, legal range 1..32.
REQ-002 Parameter DIV_W, default 24, width of the blink period register and counter, legal range 1..32.
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit reset value of the DATA register.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 address  input  3  word register index.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data; bits at and above the register width SHALL be ignored.
REQ-010 readdata  output  32  read data, zero-extended.
REQ-011 out_port  output  WIDTH  registered LED/PIO drive.

Function
REQ-012 A write SHALL occur on a rising edge when chipselect=1 and write_n=0.
REQ-013 Address 0 (DATA, rw): a write SHALL load writedata[WIDTH-1:0].
REQ-014 Address 1 (SET, wo): a write SHALL set DATA <= DATA | wd.
REQ-015 Address 2 (CLR, wo): a write SHALL set DATA <= DATA & ~wd.
REQ-016 Address 3 (TOGGLE, wo): a write SHALL set DATA <= DATA ^ wd.
REQ-017 Address 4 (BLINK_MASK, rw): a write SHALL load the WIDTH-bit mask; mask bit=1 marks that bit as blinking.
REQ-018 Address 5 (PERIOD, rw): a write SHALL load writedata[DIV_W-1:0], clear the counter to 0 and clear phase to 0 on the same edge.
REQ-019 Address 6 (STATUS, ro): bit0 SHALL read phase and bits [31:1] SHALL read 0.
REQ-020 Reads of addresses 1, 2, 3 and 7 SHALL return 0, and writes to 6 and 7 SHALL have no effect.
REQ-021 readdata SHALL be combinational from address and the current registers, with no wait states and no read side effects; chipselect is not required for readdata.
REQ-022 The counter SHALL increment every cycle, and when counter==PERIOD it SHALL wrap to 0 and toggle phase on the same edge.
REQ-023 Phase therefore SHALL toggle every PERIOD+1 cycles; with PERIOD=0 it SHALL toggle every cycle.
REQ-024 A PERIOD write coinciding with a wrap SHALL take precedence: counter=0 and phase=0.
REQ-025 Writes to BLINK_MASK or DATA SHALL NOT disturb the counter or phase.
REQ-026 On each edge, out_port SHALL be loaded with DATA & ~(BLINK_MASK & {WIDTH{phase}}), using pre-edge values.
REQ-027 Latency: a DATA or mask write at edge N SHALL be visible on out_port after edge N+1.

Reset
REQ-028 On an edge with reset_n=0: DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=all ones, counter=0, phase=0, out_port=RESET_VALUE.
REQ-029 Reset SHALL override any write in the same cycle, and reset mid-blink SHALL restart the timer from counter 0, phase 0.

Structure
REQ-030 Register address constants (0..7) and the STATUS phase bit index SHALL live in a shared package, pio_led_pkg.
REQ-031 The counter, phase and wrap logic SHALL be one sub-module, blink_timer, parametrised by DIV_W, with inputs period, restart and reset_n, and output phase.
REQ-032 The top level SHALL contain only the register file, read mux and output register.

Verification
REQ-033 Reset, then read all addresses -> DATA=RESET_VALUE, PERIOD=0xFFFFFF (DIV_W=24), all others 0, out_port=RESET_VALUE.
REQ-034 Write DATA=0xA5, SET=0x0F, CLR=0x81, TOGGLE=0xFF -> DATA reads 0xAF, 0x2E, 0xD1 in turn; each value appears on out_port one cycle after the write.
REQ-035 PERIOD=3, BLINK_MASK=0x01, DATA=0x03 -> out_port alternates 0x03/0x02 every 4 cycles, and STATUS bit0 tracks phase.
REQ-036 PERIOD=0 -> phase toggles every cycle; a PERIOD write on the wrap edge -> counter=0, phase=0 next cycle.
REQ-037 Assert reset_n=0 for 1 cycle mid-blink with a write in the same cycle -> the write is discarded, all reset values hold, and the blink restarts at phase 0.
REQ-038 WIDTH=1 and WIDTH=32 builds; write 0xFFFFFFFF to DATA -> readdata equals exactly the WIDTH-bit mask, zero-extended.
